// File: rtl/usb_bulk_out_seq.sv
// USB bulk OUT transaction sequencer.
// Tracks OUT token -> DATA0/1 -> handshake. Payload bytes go to the FIFO through
// a two-byte delay line, so the trailing CRC16 never reaches it. Each packet
// ends with either a commit or a discard pulse, and an ACK or NAK is requested
// when the packet warrants a handshake.
// Optional feature: define BULK_OUT_TIMEOUT_EN to abandon WAIT_DATA after
// TIMEOUT cycles with no PID.
module usb_bulk_out_seq #(
    parameter int MAX_PKT = 64,
    parameter int TIMEOUT = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pid_valid,
    input  logic [3:0] pid,
    input  logic       byte_valid,
    input  logic [7:0] rx_byte,
    input  logic       eop,
    input  logic       crc_ok,
    input  logic       addr_ep_match,
    input  logic [7:0] fifo_free,
    input  logic       hs_done,
    input  logic       clear_toggle,
    output logic       fifo_wr_en,
    output logic [7:0] wr_data,
    output logic       pkt_commit,
    output logic       pkt_discard,
    output logic       send_ack,
    output logic       send_nak,
    output logic       rcving,
    output logic       exp_toggle
);

    typedef enum logic [2:0] {IDLE, TOKEN, WAIT_DATA, DATA, CHECK, HS} state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    // One spare bit so MAX_PKT+3 and beyond compare without wrapping.
    localparam int CW = $clog2(MAX_PKT + 3) + 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PKT + 2);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic            ovf_reg;
    logic            nak_pend_reg;
    logic            toggle_reg;
    logic            crc_ok_reg;
    logic            exp_toggle_reg;
    logic [7:0]      dly0_reg;
    logic [7:0]      dly1_reg;
    logic            fifo_wr_en_reg;
    logic [7:0]      wr_data_reg;
    logic            pkt_commit_reg;
    logic            pkt_discard_reg;
    logic            send_ack_reg;
    logic            send_nak_reg;

`ifdef BULK_OUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]   wait_cnt_reg;
`endif

    assign cnt_next = cnt_reg + CW'(1);

    // Sequencer: state, packet bookkeeping and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            ovf_reg         <= 1'b0;
            nak_pend_reg    <= 1'b0;
            toggle_reg      <= 1'b0;
            crc_ok_reg      <= 1'b0;
            exp_toggle_reg  <= 1'b0;
            dly0_reg        <= '0;
            dly1_reg        <= '0;
            fifo_wr_en_reg  <= 1'b0;
            wr_data_reg     <= '0;
            pkt_commit_reg  <= 1'b0;
            pkt_discard_reg <= 1'b0;
            send_ack_reg    <= 1'b0;
            send_nak_reg    <= 1'b0;
`ifdef BULK_OUT_TIMEOUT_EN
            wait_cnt_reg    <= '0;
`endif
        end else begin
            fifo_wr_en_reg  <= 1'b0;
            pkt_commit_reg  <= 1'b0;
            pkt_discard_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (pid_valid && pid == PID_OUT) state_reg <= TOKEN;
                end

                TOKEN: begin
                    if (eop) begin
                        if (crc_ok && addr_ep_match) begin
                            state_reg    <= WAIT_DATA;
                            nak_pend_reg <= (int'(fifo_free) < MAX_PKT);
`ifdef BULK_OUT_TIMEOUT_EN
                            wait_cnt_reg <= '0;
`endif
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (pid_valid) begin
                        if (pid == PID_DATA0 || pid == PID_DATA1) begin
                            state_reg  <= DATA;
                            toggle_reg <= pid[3];
                            cnt_reg    <= '0;
                            ovf_reg    <= 1'b0;
                            dly0_reg   <= '0;
                            dly1_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
`ifdef BULK_OUT_TIMEOUT_EN
                    else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + TW'(1);
                    end
`endif
                end

                DATA: begin
                    if (pid_valid && !eop) begin
                        // A new PID mid-packet means the packet was cut short.
                        pkt_discard_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        if (byte_valid && !ovf_reg) begin
                            cnt_reg  <= cnt_next;
                            dly1_reg <= dly0_reg;
                            dly0_reg <= rx_byte;
                            if (cnt_next > CNT_LIM) begin
                                ovf_reg <= 1'b1;
                            end else if (cnt_reg >= CNT_TWO && !nak_pend_reg) begin
                                fifo_wr_en_reg <= 1'b1;
                                wr_data_reg    <= dly1_reg;
                            end
                        end
                        if (eop) begin
                            crc_ok_reg <= crc_ok;
                            state_reg  <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (!crc_ok_reg || ovf_reg || cnt_reg < CNT_TWO) begin
                        pkt_discard_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else if (nak_pend_reg) begin
                        pkt_discard_reg <= 1'b1;
                        send_nak_reg    <= 1'b1;
                        state_reg       <= HS;
                    end else if (toggle_reg == exp_toggle_reg) begin
                        pkt_commit_reg  <= 1'b1;
                        send_ack_reg    <= 1'b1;
                        exp_toggle_reg  <= ~exp_toggle_reg;
                        state_reg       <= HS;
                    end else begin
                        // Retransmission of an already-accepted packet: ACK, drop data.
                        pkt_discard_reg <= 1'b1;
                        send_ack_reg    <= 1'b1;
                        state_reg       <= HS;
                    end
                end

                HS: begin
                    if (hs_done) begin
                        send_ack_reg <= 1'b0;
                        send_nak_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase

            // Host-forced resync takes precedence over any flip above.
            if (clear_toggle) exp_toggle_reg <= 1'b0;
        end
    end

    assign fifo_wr_en  = fifo_wr_en_reg;
    assign wr_data     = wr_data_reg;
    assign pkt_commit  = pkt_commit_reg;
    assign pkt_discard = pkt_discard_reg;
    assign send_ack    = send_ack_reg;
    assign send_nak    = send_nak_reg;
    assign rcving      = (state_reg != IDLE);
    assign exp_toggle  = exp_toggle_reg;

endmodule

// File: tb/tb_usb_bulk_out_seq.sv
// Directed self-checking bench for usb_bulk_out_seq (MAX_PKT=64, TIMEOUT=800).
module tb_usb_bulk_out_seq;

    localparam logic [3:0] OUT_PID = 4'b0001;
    localparam logic [3:0] D0_PID  = 4'b0011;
    localparam logic [3:0] D1_PID  = 4'b1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pid_valid = 1'b0;
    logic [3:0] pid = '0;
    logic       byte_valid = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       eop = 1'b0;
    logic       crc_ok = 1'b0;
    logic       addr_ep_match = 1'b0;
    logic [7:0] fifo_free = 8'd128;
    logic       hs_done = 1'b0;
    logic       clear_toggle = 1'b0;
    logic       fifo_wr_en;
    logic [7:0] wr_data;
    logic       pkt_commit;
    logic       pkt_discard;
    logic       send_ack;
    logic       send_nak;
    logic       rcving;
    logic       exp_toggle;

    always #5 clk = ~clk;

    usb_bulk_out_seq #(.MAX_PKT(64), .TIMEOUT(800)) dut (
        .clk(clk), .rst(rst),
        .pid_valid(pid_valid), .pid(pid),
        .byte_valid(byte_valid), .rx_byte(rx_byte),
        .eop(eop), .crc_ok(crc_ok), .addr_ep_match(addr_ep_match),
        .fifo_free(fifo_free), .hs_done(hs_done), .clear_toggle(clear_toggle),
        .fifo_wr_en(fifo_wr_en), .wr_data(wr_data),
        .pkt_commit(pkt_commit), .pkt_discard(pkt_discard),
        .send_ack(send_ack), .send_nak(send_nak),
        .rcving(rcving), .exp_toggle(exp_toggle)
    );

    int n_checks = 0;
    int n_pass = 0;

    int wr_cnt = 0;
    int commit_cnt = 0;
    int discard_cnt = 0;
    int ack_seen = 0;
    int nak_seen = 0;
    logic [7:0] wr_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_cnt++;
            wr_log.push_back(wr_data);
        end
        if (pkt_commit)  commit_cnt++;
        if (pkt_discard) discard_cnt++;
        if (send_ack)    ack_seen = 1;
        if (send_nak)    nak_seen = 1;
    end

    function automatic logic [31:0] logged(input int i);
        if (i < wr_log.size()) return 32'(wr_log[i]);
        return 32'hDEAD;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_cnt = 0; commit_cnt = 0; discard_cnt = 0;
        ack_seen = 0; nak_seen = 0;
        wr_log.delete();
    endtask

    task automatic pid_pulse(input logic [3:0] p);
        pid = p; pid_valid = 1'b1;
        tick(1);
        pid_valid = 1'b0;
    endtask

    task automatic byte_pulse(input logic [7:0] b);
        rx_byte = b; byte_valid = 1'b1;
        tick(1);
        byte_valid = 1'b0;
    endtask

    task automatic eop_pulse(input logic c, input logic m);
        eop = 1'b1; crc_ok = c; addr_ep_match = m;
        tick(1);
        eop = 1'b0; crc_ok = 1'b0; addr_ep_match = 1'b0;
    endtask

    task automatic run_packet(input logic [3:0] dpid, input int nbytes, input logic dcrc,
                              input logic [7:0] free);
        clear_mon();
        fifo_free = free;
        pid_pulse(OUT_PID);
        eop_pulse(1'b1, 1'b1);
        pid_pulse(dpid);
        for (int i = 0; i < nbytes; i++) byte_pulse(8'(8'h10 + i));
        eop_pulse(dcrc, 1'b1);
    endtask

    task automatic wait_hs(input string tag, input logic want_nak);
        int k = 0;
        while (!(send_ack || send_nak) && k < 10) begin
            tick(1);
            k++;
        end
        chk({tag, " hs_seen"}, 32'(send_ack | send_nak), 32'd1);
        chk({tag, " ack"}, 32'(send_ack), 32'(!want_nak));
        chk({tag, " nak"}, 32'(send_nak), 32'(want_nak));
        tick(3);
        chk({tag, " hs_held"}, 32'(send_ack | send_nak), 32'd1);
        hs_done = 1'b1;
        tick(1);
        hs_done = 1'b0;
        chk({tag, " hs_released"}, 32'(send_ack | send_nak), 32'd0);
        chk({tag, " idle_after_hs"}, 32'(rcving), 32'd0);
    endtask

    task automatic no_hs(input string tag);
        tick(6);
        chk({tag, " no_ack"}, 32'(ack_seen), 32'd0);
        chk({tag, " no_nak"}, 32'(nak_seen), 32'd0);
        chk({tag, " idle"}, 32'(rcving), 32'd0);
    endtask

    task automatic report(input string tag);
        $display("pkt %s: writes=%0d commit=%0d discard=%0d ack=%0d nak=%0d exp_toggle=%0d",
                 tag, wr_cnt, commit_cnt, discard_cnt, ack_seen, nak_seen, exp_toggle);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst rcving", 32'(rcving), 32'd0);
        chk("rst exp_toggle", 32'(exp_toggle), 32'd0);
        chk("rst wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst ack", 32'(send_ack), 32'd0);
        chk("rst nak", 32'(send_nak), 32'd0);
        rst = 1'b0;
        tick(2);

        // A: DATA0, 8 payload + 2 CRC, room in FIFO -> commit, ACK
        run_packet(D0_PID, 10, 1'b1, 8'd128);
        wait_hs("A", 1'b0);
        report("A");
        chk("A writes", 32'(wr_cnt), 32'd8);
        chk("A first byte", logged(0), 32'h10);
        chk("A last byte", logged(7), 32'h17);
        chk("A commit", 32'(commit_cnt), 32'd1);
        chk("A discard", 32'(discard_cnt), 32'd0);
        chk("A exp_toggle", 32'(exp_toggle), 32'd1);

        // B: duplicate DATA0 -> discard, ACK, toggle unchanged
        run_packet(D0_PID, 10, 1'b1, 8'd128);
        wait_hs("B", 1'b0);
        report("B");
        chk("B commit", 32'(commit_cnt), 32'd0);
        chk("B discard", 32'(discard_cnt), 32'd1);
        chk("B exp_toggle", 32'(exp_toggle), 32'd1);

        // C: FIFO nearly full at token -> NAK, no writes
        run_packet(D1_PID, 10, 1'b1, 8'd32);
        wait_hs("C", 1'b1);
        report("C");
        chk("C writes", 32'(wr_cnt), 32'd0);
        chk("C discard", 32'(discard_cnt), 32'd1);
        chk("C commit", 32'(commit_cnt), 32'd0);
        chk("C exp_toggle", 32'(exp_toggle), 32'd1);

        // D: 70-byte DATA1 overflows -> 64 writes, discard, silent
        run_packet(D1_PID, 70, 1'b1, 8'd128);
        no_hs("D");
        report("D");
        chk("D writes", 32'(wr_cnt), 32'd64);
        chk("D last byte", logged(63), 32'h4F);
        chk("D discard", 32'(discard_cnt), 32'd1);
        chk("D commit", 32'(commit_cnt), 32'd0);

        // E: bad data CRC -> discard, silent
        run_packet(D1_PID, 10, 1'b0, 8'd128);
        no_hs("E");
        report("E");
        chk("E discard", 32'(discard_cnt), 32'd1);
        chk("E commit", 32'(commit_cnt), 32'd0);
        chk("E exp_toggle", 32'(exp_toggle), 32'd1);

        // F: zero-length DATA1 -> commit, ACK, no writes, toggle flips to 0
        run_packet(D1_PID, 2, 1'b1, 8'd128);
        wait_hs("F", 1'b0);
        report("F");
        chk("F writes", 32'(wr_cnt), 32'd0);
        chk("F commit", 32'(commit_cnt), 32'd1);
        chk("F exp_toggle", 32'(exp_toggle), 32'd0);

        // G: token with bad CRC, then token with wrong address -> back to IDLE
        clear_mon();
        pid_pulse(OUT_PID);
        eop_pulse(1'b0, 1'b1);
        tick(1);
        chk("G badcrc idle", 32'(rcving), 32'd0);
        pid_pulse(OUT_PID);
        eop_pulse(1'b1, 1'b0);
        tick(1);
        chk("G nomatch idle", 32'(rcving), 32'd0);
        report("G");

        // H: DATA0 commit sets toggle, clear_toggle forces it back to 0
        run_packet(D0_PID, 4, 1'b1, 8'd128);
        wait_hs("H", 1'b0);
        chk("H commit", 32'(commit_cnt), 32'd1);
        chk("H writes", 32'(wr_cnt), 32'd2);
        chk("H exp_toggle set", 32'(exp_toggle), 32'd1);
        clear_toggle = 1'b1;
        tick(1);
        clear_toggle = 1'b0;
        chk("H exp_toggle cleared", 32'(exp_toggle), 32'd0);
        report("H");

        // I: PID arrives before EOP -> discard, no handshake
        clear_mon();
        pid_pulse(OUT_PID);
        eop_pulse(1'b1, 1'b1);
        pid_pulse(D0_PID);
        for (int i = 0; i < 4; i++) byte_pulse(8'(8'h40 + i));
        pid_pulse(D0_PID);
        no_hs("I");
        chk("I discard", 32'(discard_cnt), 32'd1);
        chk("I commit", 32'(commit_cnt), 32'd0);
        report("I");

        // J: reset at byte 5 -> everything quiet next edge, no packet result
        clear_mon();
        pid_pulse(OUT_PID);
        eop_pulse(1'b1, 1'b1);
        pid_pulse(D0_PID);
        for (int i = 0; i < 5; i++) byte_pulse(8'(8'h50 + i));
        rst = 1'b1;
        tick(1);
        chk("J wr_en", 32'(fifo_wr_en), 32'd0);
        chk("J rcving", 32'(rcving), 32'd0);
        chk("J ack_nak", 32'(send_ack | send_nak), 32'd0);
        chk("J pulses", 32'(pkt_commit | pkt_discard), 32'd0);
        rst = 1'b0;
        tick(5);
        chk("J commit", 32'(commit_cnt), 32'd0);
        chk("J discard", 32'(discard_cnt), 32'd0);
        chk("J no hs", 32'(ack_seen | nak_seen), 32'd0);
        report("J");

        // K: token with no DATA PID following
        clear_mon();
        pid_pulse(OUT_PID);
        eop_pulse(1'b1, 1'b1);
`ifdef BULK_OUT_TIMEOUT_EN
        tick(795);
        chk("K still waiting", 32'(rcving), 32'd1);
        tick(10);
        chk("K timed out", 32'(rcving), 32'd0);
        chk("K no writes", 32'(wr_cnt), 32'd0);
        chk("K no hs", 32'(ack_seen | nak_seen), 32'd0);
`else
        tick(900);
        chk("K still waiting", 32'(rcving), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("K rst idle", 32'(rcving), 32'd0);
`endif
        report("K");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_bulk_out_seq.md
USB_BULK_OUT_SEQ -- requirements
Module: usb_bulk_out_seq

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, max bulk payload bytes per DATA packet.
REQ-002 SHALL have parameter TIMEOUT, default 800, clk cycles allowed between OUT-token EOP and DATA PID.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports pid_valid in 1 (PID-byte pulse) and pid in 4 (decoded PID, valid with pid_valid).
REQ-006 SHALL have ports byte_valid in 1 (data-byte pulse) and rx_byte in 8 (byte, valid with byte_valid).
REQ-007 SHALL have ports eop in 1 (end-of-packet pulse), crc_ok in 1 (CRC5/CRC16 result, valid with eop), and addr_ep_match in 1 (token addr/endpoint hit, valid with eop).
REQ-008 SHALL have ports fifo_free in 8 (free FIFO bytes), hs_done in 1 (handshake transmitted) and clear_toggle in 1 (force DATA0 expectation).
REQ-009 SHALL have outputs fifo_wr_en 1, wr_data 8, pkt_commit 1, pkt_discard 1, send_ack 1, send_nak 1, rcving 1, exp_toggle 1.

Function
REQ-010 SHALL implement states IDLE, TOKEN, WAIT_DATA, DATA, CHECK, HS.
REQ-011 IDLE: pid_valid with pid=4'b0001 (OUT) -> TOKEN; any other PID ignored, stay IDLE.
REQ-012 TOKEN: byte_valid ignored; on eop, crc_ok&&addr_ep_match -> WAIT_DATA, else IDLE.
REQ-013 On TOKEN->WAIT_DATA, latch nak_pend = (fifo_free < MAX_PKT).
REQ-014 WAIT_DATA: pid 4'b0011 (DATA0) or 4'b1011 (DATA1) -> DATA, latch PID toggle bit; any other PID -> IDLE, no handshake.
REQ-015 DATA: byte counter (width >= clog2(MAX_PKT+3)) increments per byte_valid, cleared on DATA entry.
REQ-016 DATA: bytes pass through a 2-deep delay line so the two CRC16 bytes never reach the FIFO; fifo_wr_en pulses, with wr_data = oldest byte, on byte_valid once the line is full, unless nak_pend or overflow.
REQ-017 Overflow: count exceeding MAX_PKT+2 sets ovf; further writes suppressed.
REQ-018 DATA: eop -> CHECK; pid_valid before eop -> pkt_discard pulse, IDLE, PID not reprocessed.
REQ-019 CHECK (1 cycle) priority: !crc_ok, ovf or count<2 -> pkt_discard, IDLE, no handshake; nak_pend -> pkt_discard, send_nak; toggle==exp_toggle -> pkt_commit, send_ack, flip exp_toggle; else (duplicate) pkt_discard, send_ack, no flip.
REQ-020 pkt_commit/pkt_discard SHALL be single-cycle pulses, mutually exclusive.
REQ-021 HS: send_ack or send_nak held high until hs_done, then both low and IDLE next cycle.
REQ-022 rcving SHALL be high in every state except IDLE.
REQ-023 clear_toggle sets exp_toggle=0 in any state; wins over a simultaneous CHECK flip.
REQ-024 Zero-length packet (count==2, crc_ok) SHALL be committed/ACKed with no FIFO writes.

Reset
REQ-025 rst SHALL force IDLE, exp_toggle=0, nak_pend=0, ovf=0, counters and delay line cleared, all outputs 0 next edge.
REQ-026 rst mid-packet SHALL emit no pkt_commit, pkt_discard or handshake.

Configuration
REQ-027 With BULK_OUT_TIMEOUT_EN defined: WAIT_DATA counter; TIMEOUT cycles without pid_valid -> IDLE, no handshake, no FIFO activity.
REQ-028 Without BULK_OUT_TIMEOUT_EN: no counter; WAIT_DATA waits until pid_valid or rst.

Verification
REQ-029 OUT, eop crc_ok match, DATA0, 10 bytes (8 payload+2 CRC), eop crc_ok, fifo_free=128 -> 8 fifo_wr_en, pkt_commit, send_ack until hs_done, exp_toggle=1.
REQ-030 Repeat DATA0 with exp_toggle=1 -> 0 commits, pkt_discard, send_ack, exp_toggle stays 1.
REQ-031 fifo_free=32 at token, MAX_PKT=64 -> no fifo_wr_en, pkt_discard, send_nak.
REQ-032 DATA1, 70 bytes, MAX_PKT=64 -> exactly 64 writes, pkt_discard, no handshake; crc_ok=0 case -> pkt_discard, no handshake.
REQ-033 With BULK_OUT_TIMEOUT_EN, no DATA PID for 800 cycles -> IDLE, rcving=0; rst asserted at byte 5 -> IDLE, all outputs 0 next edge.
